// File: rtl/riscv_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller and memory.
interface riscv_fetch_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/riscv_fetch_ctrl.sv
// Fetch controller: issues instruction-memory requests for the IF-stage PC,
// registers the result toward decode, and latches a fault on memory timeout.
module riscv_fetch_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pc,
    output logic                      bubble,
    riscv_fetch_ctrl_if.master        imem,
    input  logic                      redirect,
    input  logic                      id_stall,
    output logic                      id_valid,
    output logic [31:0]               id_instr,
    output logic [31:0]               id_pc,
    output logic                      fault
);

    typedef enum logic {
        ST_FETCH,
        ST_FAULT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       hold;
    logic       fire;
    logic       wait_miss;

    assign hold      = id_valid & id_stall;
    // rst gates the request so it drops the instant reset asserts, without a clock edge.
    assign imem.req  = (state == ST_FETCH) & ~hold & rst;
    assign imem.addr = pc;
    assign fire      = (state == ST_FETCH) & imem.req & imem.ack & ~redirect;
    assign bubble    = ~fire;
    assign wait_miss = imem.req & ~imem.ack & ~redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_FETCH;
            wait_cnt <= '0;
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
            fault    <= 1'b0;
        end else if (state == ST_FETCH) begin
            if (fire) begin
                id_valid <= 1'b1;
                id_instr <= imem.data;
                id_pc    <= pc;
            end else if (redirect || !hold) begin
                id_valid <= 1'b0;
            end

            if (!wait_miss) begin
                wait_cnt <= '0;
            end else if (wait_cnt == WAIT_LAST) begin
                state    <= ST_FAULT;
                fault    <= 1'b1;
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end else begin
            // Sticky until reset; redirect and late acks are ignored here.
            id_valid <= 1'b0;
            wait_cnt <= '0;
            fault    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Directed bench for riscv_fetch_ctrl; the bench plays the IF stage (PC += 4 on bubble=0).
module tb_riscv_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        bubble;
    logic        redirect;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fault;

    int n_checks;
    int n_pass;

    riscv_fetch_ctrl_if imem_bus ();

    riscv_fetch_ctrl #(.MAX_WAIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .bubble   (bubble),
        .imem     (imem_bus),
        .redirect (redirect),
        .id_stall (id_stall),
        .id_valid (id_valid),
        .id_instr (id_instr),
        .id_pc    (id_pc),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // One clock: sample bubble before the edge, advance the PC after it like the IF stage.
    task automatic cycle();
        logic adv;
        @(negedge clk);
        adv = !bubble;
        @(posedge clk);
        #1;
        if (adv) pc = pc + 32'd4;
        imem_bus.data = {16'hC0DE, pc[15:0]};
        #1;
    endtask

    task automatic do_reset(input logic ack);
        rst = 1'b0;
        redirect = 1'b0;
        id_stall = 1'b0;
        imem_bus.ack = ack;
        pc = 32'd0;
        imem_bus.data = 32'hC0DE_0000;
        cycle();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc = 32'd0;
        redirect = 1'b0;
        id_stall = 1'b0;
        imem_bus.ack = 1'b1;
        imem_bus.data = 32'hDEAD_BEEF;
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (imem_bus.req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_bus.req); else n_pass++;
        n_checks++; if (bubble !== 1'b1) $display("FAIL rst_bubble: got %b want 1", bubble); else n_pass++;
        cycle();
        cycle();
        n_checks++; if (id_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", id_valid); else n_pass++;
        n_checks++; if (id_instr !== 32'd0) $display("FAIL rst_instr: got %h want 0", id_instr); else n_pass++;
        n_checks++; if (id_pc !== 32'd0) $display("FAIL rst_idpc: got %h want 0", id_pc); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault); else n_pass++;
        n_checks++; if (imem_bus.req !== 1'b0) $display("FAIL rst_req_edge: got %b want 0", imem_bus.req); else n_pass++;
        n_checks++; if (pc !== 32'd0) $display("FAIL rst_pc: got %h want 0", pc); else n_pass++;
    endtask

    task automatic test_zero_wait();
        do_reset(1'b1);
        n_checks++; if (imem_bus.req !== 1'b1) $display("FAIL zw_req: got %b want 1", imem_bus.req); else n_pass++;
        n_checks++; if (imem_bus.addr !== 32'd0) $display("FAIL zw_addr: got %h want 0", imem_bus.addr); else n_pass++;
        n_checks++; if (bubble !== 1'b0) $display("FAIL zw_bubble: got %b want 0", bubble); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(4 * i);
            cycle();
            n_checks++; if (id_valid !== 1'b1) $display("FAIL zw_valid[%0d]: got %b want 1", i, id_valid); else n_pass++;
            n_checks++; if (id_pc !== exp_pc) $display("FAIL zw_idpc[%0d]: got %h want %h", i, id_pc, exp_pc); else n_pass++;
            n_checks++; if (id_instr !== {16'hC0DE, exp_pc[15:0]}) $display("FAIL zw_instr[%0d]: got %h want %h", i, id_instr, {16'hC0DE, exp_pc[15:0]}); else n_pass++;
            n_checks++; if (bubble !== 1'b0) $display("FAIL zw_bubble[%0d]: got %b want 0", i, bubble); else n_pass++;
        end
        n_checks++; if (pc !== 32'd16) $display("FAIL zw_pc: got %h want 10", pc); else n_pass++;
    endtask

    task automatic test_wait_states();
        do_reset(1'b1);
        cycle();
        imem_bus.ack = 1'b0;
        #1;
        n_checks++; if (pc !== 32'd4) $display("FAIL ws_pc_start: got %h want 4", pc); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (bubble !== 1'b1) $display("FAIL ws_bubble[%0d]: got %b want 1", i, bubble); else n_pass++;
            n_checks++; if (imem_bus.addr !== 32'd4) $display("FAIL ws_addr[%0d]: got %h want 4", i, imem_bus.addr); else n_pass++;
            n_checks++; if (imem_bus.req !== 1'b1) $display("FAIL ws_req[%0d]: got %b want 1", i, imem_bus.req); else n_pass++;
            cycle();
            n_checks++; if (id_valid !== 1'b0) $display("FAIL ws_valid[%0d]: got %b want 0", i, id_valid); else n_pass++;
        end
        imem_bus.ack = 1'b1;
        #1;
        n_checks++; if (bubble !== 1'b0) $display("FAIL ws_ack_bubble: got %b want 0", bubble); else n_pass++;
        cycle();
        n_checks++; if (id_valid !== 1'b1) $display("FAIL ws_valid_ack: got %b want 1", id_valid); else n_pass++;
        n_checks++; if (id_pc !== 32'd4) $display("FAIL ws_idpc: got %h want 4", id_pc); else n_pass++;
        n_checks++; if (id_instr !== 32'hC0DE_0004) $display("FAIL ws_instr: got %h want c0de0004", id_instr); else n_pass++;
        n_checks++; if (pc !== 32'd8) $display("FAIL ws_pc_next: got %h want 8", pc); else n_pass++;
    endtask

    // Continues from test_wait_states: pc=8, ack held high.
    task automatic test_decode_stall();
        cycle();
        n_checks++; if (id_pc !== 32'd8) $display("FAIL st_idpc_pre: got %h want 8", id_pc); else n_pass++;
        id_stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (imem_bus.req !== 1'b0) $display("FAIL st_req[%0d]: got %b want 0", i, imem_bus.req); else n_pass++;
            n_checks++; if (bubble !== 1'b1) $display("FAIL st_bubble[%0d]: got %b want 1", i, bubble); else n_pass++;
            cycle();
            n_checks++; if (id_valid !== 1'b1) $display("FAIL st_valid[%0d]: got %b want 1", i, id_valid); else n_pass++;
            n_checks++; if (id_pc !== 32'd8) $display("FAIL st_idpc[%0d]: got %h want 8", i, id_pc); else n_pass++;
            n_checks++; if (id_instr !== 32'hC0DE_0008) $display("FAIL st_instr[%0d]: got %h want c0de0008", i, id_instr); else n_pass++;
            n_checks++; if (pc !== 32'd12) $display("FAIL st_pc[%0d]: got %h want c", i, pc); else n_pass++;
        end
        id_stall = 1'b0;
        #1;
        n_checks++; if (imem_bus.req !== 1'b1) $display("FAIL st_resume_req: got %b want 1", imem_bus.req); else n_pass++;
        n_checks++; if (imem_bus.addr !== 32'd12) $display("FAIL st_resume_addr: got %h want c", imem_bus.addr); else n_pass++;
        cycle();
        n_checks++; if (id_pc !== 32'd12) $display("FAIL st_resume_idpc: got %h want c", id_pc); else n_pass++;
    endtask

    // Continues from test_decode_stall: pc=16, id_instr=c0de000c, ack held high.
    task automatic test_redirect();
        redirect = 1'b1;
        #1;
        n_checks++; if (bubble !== 1'b1) $display("FAIL rd_bubble: got %b want 1", bubble); else n_pass++;
        cycle();
        n_checks++; if (id_valid !== 1'b0) $display("FAIL rd_valid: got %b want 0", id_valid); else n_pass++;
        n_checks++; if (id_instr !== 32'hC0DE_000C) $display("FAIL rd_discard: got %h want c0de000c", id_instr); else n_pass++;
        n_checks++; if (pc !== 32'd16) $display("FAIL rd_pc: got %h want 10", pc); else n_pass++;
        redirect = 1'b0;
        #1;
        cycle();
        n_checks++; if (id_pc !== 32'd16) $display("FAIL rd_refetch: got %h want 10", id_pc); else n_pass++;
        id_stall = 1'b1;
        redirect = 1'b1;
        #1;
        cycle();
        n_checks++; if (id_valid !== 1'b0) $display("FAIL rd_hold_valid: got %b want 0", id_valid); else n_pass++;
        n_checks++; if (pc !== 32'd20) $display("FAIL rd_hold_pc: got %h want 14", pc); else n_pass++;
        id_stall = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset(1'b0);
        repeat (3) cycle();
        n_checks++; if (fault !== 1'b0) $display("FAIL to_early: got %b want 0", fault); else n_pass++;
        imem_bus.ack = 1'b1;
        #1;
        cycle();
        imem_bus.ack = 1'b0;
        #1;
        repeat (3) cycle();
        n_checks++; if (fault !== 1'b0) $display("FAIL to_cnt_clear: got %b want 0", fault); else n_pass++;
        n_checks++; if (imem_bus.req !== 1'b1) $display("FAIL to_req_pre: got %b want 1", imem_bus.req); else n_pass++;
        cycle();
        n_checks++; if (fault !== 1'b1) $display("FAIL to_fault: got %b want 1", fault); else n_pass++;
        n_checks++; if (imem_bus.req !== 1'b0) $display("FAIL to_req: got %b want 0", imem_bus.req); else n_pass++;
        n_checks++; if (bubble !== 1'b1) $display("FAIL to_bubble: got %b want 1", bubble); else n_pass++;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL to_valid: got %b want 0", id_valid); else n_pass++;
        imem_bus.ack = 1'b1;
        redirect = 1'b1;
        repeat (2) cycle();
        n_checks++; if (fault !== 1'b1) $display("FAIL to_sticky: got %b want 1", fault); else n_pass++;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL to_late_ack: got %b want 0", id_valid); else n_pass++;
        n_checks++; if (pc !== 32'd4) $display("FAIL to_pc: got %h want 4", pc); else n_pass++;
        redirect = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++; if (fault !== 1'b0) $display("FAIL to_rst_clear: got %b want 0", fault); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1);
        repeat (2) cycle();
        imem_bus.ack = 1'b0;
        #1;
        n_checks++; if (id_valid !== 1'b1) $display("FAIL rm_pre_valid: got %b want 1", id_valid); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", id_valid); else n_pass++;
        n_checks++; if (imem_bus.req !== 1'b0) $display("FAIL rm_req: got %b want 0", imem_bus.req); else n_pass++;
        n_checks++; if (id_pc !== 32'd0) $display("FAIL rm_idpc: got %h want 0", id_pc); else n_pass++;
        n_checks++; if (bubble !== 1'b1) $display("FAIL rm_bubble: got %b want 1", bubble); else n_pass++;
        pc = 32'd0;
        imem_bus.ack = 1'b1;
        cycle();
        rst = 1'b1;
        #1;
        n_checks++; if (imem_bus.addr !== 32'd0) $display("FAIL rm_addr: got %h want 0", imem_bus.addr); else n_pass++;
        cycle();
        n_checks++; if (id_valid !== 1'b1) $display("FAIL rm_first_valid: got %b want 1", id_valid); else n_pass++;
        n_checks++; if (id_pc !== 32'd0) $display("FAIL rm_first_pc: got %h want 0", id_pc); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_decode_stall();
        test_redirect();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_ctrl.md
RISCV_FETCH_CTRL -- requirements
Module: riscv_fetch_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning consecutive un-acked request cycles before fault (legal range 1..255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pc  input  32  current fetch PC from the IF stage.
REQ-005 SHALL have port bubble  output  1  driven to the IF stage; 1 holds the PC, 0 lets the PC advance by 4.
REQ-006 SHALL have port imem_req  output  1  instruction memory request.
REQ-007 SHALL have port imem_addr  output  32  request address.
REQ-008 SHALL have port imem_ack  input  1  memory completion, sampled only while imem_req=1.
REQ-009 SHALL have port imem_data  input  32  instruction word, valid when imem_ack=1.
REQ-010 SHALL have port redirect  input  1  branch/jump flush request.
REQ-011 SHALL have port id_stall  input  1  decode cannot accept.
REQ-012 SHALL have ports id_valid  output  1, id_instr  output  32, id_pc  output  32  registered fetch result to decode.
REQ-013 SHALL have port fault  output  1  fetch timeout flag.

Function
REQ-014 SHALL implement two states, FETCH and FAULT.
REQ-015 SHALL define hold = id_valid & id_stall.
REQ-016 SHALL define fire = (state==FETCH) & imem_req & imem_ack & ~redirect.
REQ-017 SHALL drive imem_req = (state==FETCH) & ~hold & rst, combinationally.
REQ-018 SHALL drive imem_addr = pc combinationally, so it is stable while the request is pending.
REQ-019 SHALL drive bubble = ~fire combinationally, so the PC advances only in the cycle an instruction is accepted.
REQ-020 On an edge with fire=1, SHALL load id_valid<=1, id_instr<=imem_data and id_pc<=pc (one-cycle latency from ack).
REQ-021 On an edge with hold=1 and redirect=0, SHALL keep id_valid, id_instr and id_pc unchanged.
REQ-022 On an edge with fire=0 and hold=0, SHALL clear id_valid to 0 and keep id_instr and id_pc unchanged.
REQ-023 On an edge with redirect=1, SHALL clear id_valid to 0 regardless of hold or imem_ack, and SHALL discard any instruction returned in that cycle.
REQ-024 SHALL keep an 8-bit wait counter that increments on each edge with imem_req=1, imem_ack=0 and redirect=0, and clears to 0 otherwise.
REQ-025 When the wait counter equals MAX_WAIT-1 and another un-acked request cycle occurs, SHALL move to FAULT at that edge.
REQ-026 In FAULT, SHALL force fault=1, imem_req=0, bubble=1 and id_valid=0.
REQ-027 SHALL leave FAULT only through reset; redirect SHALL have no effect in FAULT.
REQ-028 On a simultaneous imem_ack and redirect, SHALL give redirect priority (no capture, bubble=1).
REQ-029 On a simultaneous hold and imem_ack, the ack cannot occur because imem_req=0; SHALL ignore imem_ack whenever imem_req=0.

Reset
REQ-030 While rst=0, SHALL force state=FETCH, id_valid=0, id_instr=0, id_pc=0, wait counter=0 and fault=0, asynchronously.
REQ-031 While rst=0, SHALL hold imem_req=0 and bubble=1.
REQ-032 On the first edge after rst rises, SHALL begin issuing requests immediately.
REQ-033 Reset asserted mid-request SHALL abandon the request without capturing data.

Verification
REQ-034 Zero-wait: reset, imem_ack=1 constant, id_stall=0 -> bubble=0; id_valid=1 with id_pc=0,4,8,12 on successive edges; id_instr equals imem_data of the prior cycle.
REQ-035 Wait states: imem_ack low 2 cycles at pc=4 -> bubble=1 and imem_addr=4 for 2 cycles; third cycle ack -> id_pc=4, then pc=8.
REQ-036 Decode stall: id_stall=1 while id_valid=1 with id_pc=8 -> imem_req=0, bubble=1, id_pc/id_instr frozen for 3 cycles; release -> request resumes at pc=12.
REQ-037 Redirect: redirect=1 coincident with imem_ack at pc=16 -> id_valid=0 next edge, bubble=1, PC stays 16; redirect during hold also clears id_valid.
REQ-038 Timeout: MAX_WAIT=4, imem_ack=0 forever -> fault=1 after the 4th request cycle, imem_req=0, bubble=1; later ack is ignored; rst=0 clears fault.
REQ-039 Reset mid-operation: rst=0 during a wait state -> id_valid=0, imem_req=0 immediately (no clock edge needed); after release, the first request is issued at pc=0.
